// File: rtl/axis_segment_sequencer_if.sv
// Command stream and reader-control bundle of the segment sequencer.
// slave = sequencer side, master = command source / reader side.
interface axis_segment_sequencer_if #(
  parameter int BRAM_ADDR_WIDTH = 10
);
  logic [2*BRAM_ADDR_WIDTH:0]   s_axis_cmd_tdata;
  logic                         s_axis_cmd_tvalid;
  logic                         s_axis_cmd_tready;
  logic                         rdr_aresetn;
  logic [BRAM_ADDR_WIDTH-1:0]   rdr_current_offset;
  logic [BRAM_ADDR_WIDTH-1:0]   rdr_cfg_data;
  logic                         rdr_buffer_select;
  logic                         rdr_done_tvalid;
  logic                         rdr_done_tready;

  modport slave (
    input  s_axis_cmd_tdata, s_axis_cmd_tvalid, rdr_done_tvalid,
    output s_axis_cmd_tready, rdr_aresetn, rdr_current_offset,
           rdr_cfg_data, rdr_buffer_select, rdr_done_tready
  );

  modport master (
    output s_axis_cmd_tdata, s_axis_cmd_tvalid, rdr_done_tvalid,
    input  s_axis_cmd_tready, rdr_aresetn, rdr_current_offset,
           rdr_cfg_data, rdr_buffer_select, rdr_done_tready
  );
endinterface

// File: rtl/axis_segment_sequencer.sv
// Launches one segmented-BRAM-reader playback per accepted descriptor and
// waits for the reader's completion handshake, with timeout/abort/status.
module axis_segment_sequencer #(
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int TRIG_CYCLES     = 3,
  parameter int TIMEOUT_WIDTH   = 24,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axis_segment_sequencer_if.slave   bus,
  input  logic [TIMEOUT_WIDTH-1:0]  cfg_timeout,
  input  logic                      abort,
  input  logic                      err_clear,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      seg_count,
  output logic                      err_invalid,
  output logic                      err_timeout
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam int TCW = $clog2(TRIG_CYCLES) + 1;

  logic [1:0]                 state;
  logic [TCW-1:0]             trig_cnt;
  logic [TIMEOUT_WIDTH-1:0]   tmo_cnt, tmo_lim;
  logic [BRAM_ADDR_WIDTH-1:0] cmd_start, cmd_end;
  logic                       cmd_buf;
  logic                       done, tmo_hit, run_exit, run_fault;

  assign cmd_start = bus.s_axis_cmd_tdata[BRAM_ADDR_WIDTH-1:0];
  assign cmd_end   = bus.s_axis_cmd_tdata[2*BRAM_ADDR_WIDTH-1:BRAM_ADDR_WIDTH];
  assign cmd_buf   = bus.s_axis_cmd_tdata[2*BRAM_ADDR_WIDTH];

  // Done wins over abort, abort over timeout; a completed segment is never flagged.
  assign done      = bus.rdr_done_tvalid && bus.rdr_done_tready;
  assign tmo_hit   = (tmo_lim != '0) && (tmo_cnt == tmo_lim - TIMEOUT_WIDTH'(1));
  assign run_exit  = done || abort || tmo_hit;
  assign run_fault = !done && (abort || tmo_hit);

  assign busy = (state != S_IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state                  <= S_IDLE;
      trig_cnt               <= '0;
      tmo_cnt                <= '0;
      tmo_lim                <= '0;
      seg_count              <= '0;
      err_invalid            <= 1'b0;
      err_timeout            <= 1'b0;
      bus.s_axis_cmd_tready  <= 1'b0;
      bus.rdr_aresetn        <= 1'b0;
      bus.rdr_current_offset <= '0;
      bus.rdr_cfg_data       <= '0;
      bus.rdr_buffer_select  <= 1'b0;
      bus.rdr_done_tready    <= 1'b0;
    end else begin
      // Clear first so a coincident set below takes precedence.
      if (err_clear) begin
        err_invalid <= 1'b0;
        err_timeout <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          bus.s_axis_cmd_tready <= !abort;
          if (bus.s_axis_cmd_tvalid && bus.s_axis_cmd_tready) begin
            if (cmd_start < cmd_end) begin
              state                  <= S_LOAD;
              bus.s_axis_cmd_tready  <= 1'b0;
              bus.rdr_current_offset <= cmd_start;
              bus.rdr_cfg_data       <= cmd_end;
              bus.rdr_buffer_select  <= cmd_buf;
              trig_cnt               <= '0;
            end else begin
              err_invalid <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (trig_cnt == TCW'(TRIG_CYCLES - 1)) begin
            state               <= S_RUN;
            bus.rdr_aresetn     <= 1'b1;
            bus.rdr_done_tready <= 1'b1;
            tmo_cnt             <= '0;
            tmo_lim             <= cfg_timeout;
          end else begin
            trig_cnt <= trig_cnt + TCW'(1);
          end
        end
        S_RUN: begin
          tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
          if (run_exit) begin
            state                 <= S_IDLE;
            bus.rdr_aresetn       <= 1'b0;
            bus.rdr_done_tready   <= 1'b0;
            bus.s_axis_cmd_tready <= !abort;
          end
          if (done)      seg_count   <= seg_count + CNT_WIDTH'(1);
          if (run_fault) err_timeout <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_segment_sequencer.sv
// Scoreboarded bench for axis_segment_sequencer: launched offsets are checked
// against descriptors queued at acceptance; one task per scenario.
module tb_axis_segment_sequencer;
  localparam int AW = 10, TRIG = 3, TW = 24, CW = 4;

  typedef struct packed {
    logic          b;
    logic [AW-1:0] en;
    logic [AW-1:0] st;
  } desc_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [TW-1:0] cfg_timeout;
  logic          abort, err_clear, busy, err_invalid, err_timeout;
  logic [CW-1:0] seg_count;

  axis_segment_sequencer_if #(.BRAM_ADDR_WIDTH(AW)) bus ();

  axis_segment_sequencer #(
    .BRAM_ADDR_WIDTH(AW), .TRIG_CYCLES(TRIG), .TIMEOUT_WIDTH(TW), .CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus), .cfg_timeout(cfg_timeout),
    .abort(abort), .err_clear(err_clear), .busy(busy), .seg_count(seg_count),
    .err_invalid(err_invalid), .err_timeout(err_timeout)
  );

  always #5 aclk = ~aclk;

  int            total = 0, bad = 0;
  desc_t         exp_q[$];
  logic [CW-1:0] exp_cnt = '0;

  function automatic desc_t mk(bit b, int en, int st);
    desc_t d;
    d.b = b; d.en = AW'(en); d.st = AW'(st);
    return d;
  endfunction

  function automatic desc_t offs();
    return {bus.rdr_buffer_select, bus.rdr_cfg_data, bus.rdr_current_offset};
  endfunction

  // Present one descriptor until accepted; valid ones go to the scoreboard.
  task automatic send(input desc_t d);
    bit acc = 0;
    @(negedge aclk);
    bus.s_axis_cmd_tdata = d; bus.s_axis_cmd_tvalid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (bus.s_axis_cmd_tready) begin @(posedge aclk); #1; acc = 1; end
      else @(negedge aclk);
    end
    bus.s_axis_cmd_tvalid = 1'b0;
    if (!acc) begin total++; bad++; $display("FAIL send_accept: tready=0 after 50 cycles, want 1"); end
    else if (d.st < d.en) exp_q.push_back(d);
  endtask

  task automatic wait_launch(output int low);
    bit up = 0;
    low = 0;
    for (int i = 0; i < 200 && !up; i++) begin
      @(negedge aclk);
      if (bus.rdr_aresetn) up = 1; else low++;
    end
    if (!up) begin total++; bad++; $display("FAIL launch_wait: rdr_aresetn=0 after 200 cycles, want 1"); end
  endtask

  task automatic drive_done();
    @(negedge aclk); bus.rdr_done_tvalid = 1'b1;
    @(posedge aclk); #1; bus.rdr_done_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    bus.s_axis_cmd_tdata = '0; bus.s_axis_cmd_tvalid = 1'b0; bus.rdr_done_tvalid = 1'b0;
    cfg_timeout = '0; abort = 1'b0; err_clear = 1'b0; aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    total++;
    if ({bus.rdr_aresetn, bus.s_axis_cmd_tready, bus.rdr_done_tready, busy, err_invalid, err_timeout} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000",
        {bus.rdr_aresetn, bus.s_axis_cmd_tready, bus.rdr_done_tready, busy, err_invalid, err_timeout});
    end
    total++;
    if (seg_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", seg_count); end
    total++;
    if (offs() !== '0) begin bad++; $display("FAIL reset_offsets: got %h want 0", offs()); end
    aresetn = 1'b1;
    @(negedge aclk);
    total++;
    if (bus.s_axis_cmd_tready !== 1'b1) begin bad++; $display("FAIL reset_first_tready: got %b want 1", bus.s_axis_cmd_tready); end
  endtask

  task automatic test_basic();
    desc_t d = mk(1, 20, 4), e;
    int low = 0; bit stable = 1, up = 0;
    send(d);
    for (int i = 0; i < 20 && !up; i++) begin
      @(negedge aclk);
      if (bus.rdr_aresetn) up = 1;
      else begin low++; if (offs() !== d) stable = 0; end
    end
    total++;
    if (low !== TRIG) begin bad++; $display("FAIL basic_trig_low: got %0d want %0d", low, TRIG); end
    total++;
    if (stable !== 1'b1) begin bad++; $display("FAIL basic_load_stable: got %b want 1", stable); end
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL basic_launch: got launch want none queued"); end
    else begin
      e = exp_q.pop_front();
      if (offs() !== e) begin bad++; $display("FAIL basic_launch: got %h want %h", offs(), e); end
    end
    repeat (2) @(negedge aclk);
    drive_done(); exp_cnt++;
    @(negedge aclk);
    total++;
    if (seg_count !== exp_cnt) begin bad++; $display("FAIL basic_count: got %0d want %0d", seg_count, exp_cnt); end
    total++;
    if ({busy, bus.rdr_aresetn, bus.s_axis_cmd_tready} !== 3'b001) begin
      bad++; $display("FAIL basic_idle: got %b want 001", {busy, bus.rdr_aresetn, bus.s_axis_cmd_tready});
    end
  endtask

  task automatic test_invalid();
    bit rose = 0;
    total++;
    if (err_invalid !== 1'b0) begin bad++; $display("FAIL invalid_pre: got %b want 0", err_invalid); end
    send(mk(0, 30, 30));
    send(mk(0, 10, 40));
    repeat (10) begin @(negedge aclk); if (bus.rdr_aresetn) rose = 1; end
    total++;
    if (rose !== 1'b0) begin bad++; $display("FAIL invalid_launch: got rise=%b want 0", rose); end
    total++;
    if (err_invalid !== 1'b1) begin bad++; $display("FAIL invalid_flag: got %b want 1", err_invalid); end
    total++;
    if (seg_count !== exp_cnt || busy !== 1'b0) begin
      bad++; $display("FAIL invalid_count: got %0d busy=%b want %0d busy=0", seg_count, busy, exp_cnt);
    end
    @(negedge aclk); err_clear = 1'b1; @(posedge aclk); #1; err_clear = 1'b0;
    @(negedge aclk);
    total++;
    if (err_invalid !== 1'b0) begin bad++; $display("FAIL invalid_clear: got %b want 0", err_invalid); end
  endtask

  task automatic test_timeout();
    desc_t e;
    int low, run = 1;
    bit fell = 0;
    cfg_timeout = TW'(100);
    send(mk(0, 50, 7));
    wait_launch(low);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL timeout_launch: got launch want none queued"); end
    else begin
      e = exp_q.pop_front();
      if (offs() !== e) begin bad++; $display("FAIL timeout_launch: got %h want %h", offs(), e); end
    end
    cfg_timeout = TW'(5);
    for (int i = 0; i < 300 && !fell; i++) begin
      @(negedge aclk);
      if (!bus.rdr_aresetn) fell = 1; else run++;
    end
    total++;
    if (run !== 100) begin bad++; $display("FAIL timeout_run_cycles: got %0d want 100", run); end
    total++;
    if ({err_timeout, busy} !== 2'b10 || seg_count !== exp_cnt) begin
      bad++; $display("FAIL timeout_flags: got err=%b busy=%b cnt=%0d want 1 0 %0d", err_timeout, busy, seg_count, exp_cnt);
    end
    cfg_timeout = '0;
    @(negedge aclk); err_clear = 1'b1; @(posedge aclk); #1; err_clear = 1'b0;
    @(negedge aclk);
    total++;
    if (err_timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b want 0", err_timeout); end
  endtask

  task automatic test_done_abort();
    desc_t e;
    int low;
    send(mk(1, 900, 100));
    wait_launch(low);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL doneabort_launch: got launch want none queued"); end
    else begin
      e = exp_q.pop_front();
      if (offs() !== e) begin bad++; $display("FAIL doneabort_launch: got %h want %h", offs(), e); end
    end
    @(negedge aclk); bus.rdr_done_tvalid = 1'b1; abort = 1'b1;
    @(posedge aclk); #1; bus.rdr_done_tvalid = 1'b0; abort = 1'b0;
    exp_cnt++;
    @(negedge aclk);
    total++;
    if (seg_count !== exp_cnt || err_timeout !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL doneabort: got cnt=%0d err=%b busy=%b want %0d 0 0", seg_count, err_timeout, busy, exp_cnt);
    end
  endtask

  task automatic test_abort();
    desc_t e;
    int low;
    send(mk(0, 300, 200));
    wait_launch(low);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    @(negedge aclk); abort = 1'b1; @(posedge aclk); #1; abort = 1'b0;
    @(negedge aclk);
    total++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || seg_count !== exp_cnt) begin
      bad++; $display("FAIL abort_run: got err=%b busy=%b cnt=%0d want 1 0 %0d", err_timeout, busy, seg_count, exp_cnt);
    end
    @(negedge aclk); err_clear = 1'b1; @(posedge aclk); #1; err_clear = 1'b0;
    // Abort during LOAD: back to IDLE with no launch and no error.
    send(mk(1, 5, 2));
    if (exp_q.size() != 0) e = exp_q.pop_front();
    @(negedge aclk); abort = 1'b1;
    @(negedge aclk);
    total++;
    if ({busy, bus.rdr_aresetn, bus.s_axis_cmd_tready, err_timeout} !== 4'b0000) begin
      bad++; $display("FAIL abort_load: got %b want 0000", {busy, bus.rdr_aresetn, bus.s_axis_cmd_tready, err_timeout});
    end
    @(negedge aclk);
    total++;
    if (bus.s_axis_cmd_tready !== 1'b0) begin bad++; $display("FAIL abort_idle_block: got %b want 0", bus.s_axis_cmd_tready); end
    abort = 1'b0;
    @(negedge aclk);
    total++;
    if (bus.s_axis_cmd_tready !== 1'b1) begin bad++; $display("FAIL abort_release: got %b want 1", bus.s_axis_cmd_tready); end
  endtask

  task automatic test_back_to_back();
    desc_t tab[4];
    tab[0] = mk(0, 100, 5); tab[1] = mk(1, 63, 2); tab[2] = mk(0, 1023, 0); tab[3] = mk(1, 12, 11);
    fork
      begin
        @(negedge aclk);
        for (int k = 0; k < 4; k++) begin
          bit acc = 0;
          if (k > 0) @(negedge aclk);
          bus.s_axis_cmd_tdata = tab[k]; bus.s_axis_cmd_tvalid = 1'b1;
          for (int i = 0; i < 100 && !acc; i++) begin
            if (bus.s_axis_cmd_tready) begin @(posedge aclk); #1; exp_q.push_back(tab[k]); acc = 1; end
            else @(negedge aclk);
          end
          if (!acc) begin total++; bad++; $display("FAIL b2b_accept: desc %0d not taken, want taken", k); end
        end
        bus.s_axis_cmd_tvalid = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) begin
          desc_t e;
          int low;
          bit stable = 1;
          wait_launch(low);
          total++;
          if (low < TRIG) begin bad++; $display("FAIL b2b_gap: got %0d want >=%0d", low, TRIG); end
          total++;
          if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_launch: got launch want none queued"); e = '0; end
          else begin
            e = exp_q.pop_front();
            if (offs() !== e) begin bad++; $display("FAIL b2b_launch: got %h want %h", offs(), e); end
          end
          repeat (3) begin @(negedge aclk); if (offs() !== e || !bus.rdr_aresetn) stable = 0; end
          total++;
          if (stable !== 1'b1) begin bad++; $display("FAIL b2b_run_stable: got %b want 1", stable); end
          drive_done(); exp_cnt++;
        end
      end
    join
    @(negedge aclk);
    total++;
    if (seg_count !== exp_cnt || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_count: got %0d q=%0d want %0d q=0", seg_count, exp_q.size(), exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    int low;
    send(mk(1, 700, 600));
    wait_launch(low);
    #2; aresetn = 1'b0;
    #1;
    total++;
    if ({bus.rdr_aresetn, busy, bus.s_axis_cmd_tready, bus.rdr_done_tready} !== 4'b0000) begin
      bad++; $display("FAIL async_reset_ctl: got %b want 0000", {bus.rdr_aresetn, busy, bus.s_axis_cmd_tready, bus.rdr_done_tready});
    end
    total++;
    if (seg_count !== '0 || offs() !== '0) begin
      bad++; $display("FAIL async_reset_state: got cnt=%0d offs=%h want 0 0", seg_count, offs());
    end
    exp_cnt = '0; exp_q.delete();
    @(negedge aclk); aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 17; n++) begin
      desc_t e;
      int low;
      send(mk(n & 1, n * 9 + 3, n));
      wait_launch(low);
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL wrap_launch: seg %0d got launch want none queued", n); end
      else begin
        e = exp_q.pop_front();
        if (offs() !== e) begin bad++; $display("FAIL wrap_launch: seg %0d got %h want %h", n, offs(), e); end
      end
      drive_done(); exp_cnt++;
    end
    @(negedge aclk);
    total++;
    if (seg_count !== exp_cnt) begin bad++; $display("FAIL wrap_count: got %0d want %0d", seg_count, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_timeout();
    test_done_abort();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
